// File: rtl/pipe_boot_ctrl.sv
// Boot sequencer and data-RAM port arbiter for the pipelined core.
// Define PIPE_BOOT_DBG_WRITE_EN to let the debug port write RAM while halted.
//
// state  | meaning
// IDLE   | out of reset, every stage held in reset
// REL_FD | fetch/decode released (or re-arming after a restart from HALT)
// REL_E  | execute released
// REL_M  | memory released
// RUN    | core running, cycle counter active
// DRAIN  | fetch frozen, bubbles flow through E/M/W
// HALT   | core stopped, RAM port owned by the debug requester
module pipe_boot_ctrl #(
  parameter int unsigned STAGE_GAP = 1,
  parameter int unsigned RUN_LIMIT = 0,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic [31:0] core_addr,
  input  logic        core_we,
  input  logic [31:0] core_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_valid,
  output logic        dbg_err,
  output logic        reset_F,
  output logic        reset_D,
  output logic        reset_E,
  output logic        reset_M,
  output logic        reset_W,
  output logic        pc_sel,
  output logic        en_F,
  output logic        en_D,
  output logic        busy,
  output logic        halted,
  output logic [31:0] cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_REL_FD, S_REL_E, S_REL_M, S_RUN, S_DRAIN, S_HALT
  } state_t;

  localparam int unsigned GAP_C  = (STAGE_GAP < 1) ? 1 : STAGE_GAP;
  localparam int unsigned DRN_C  = (DRAIN_CYC < 1) ? 1 : DRAIN_CYC;
  localparam logic [31:0] GAP_LD = 32'(GAP_C - 1);
  localparam logic [31:0] DRN_LD = 32'(DRN_C - 1);
  localparam bit          LIM_EN = (RUN_LIMIT != 0);
  localparam logic [31:0] RUN_TC = LIM_EN ? 32'(RUN_LIMIT - 1) : 32'd0;

  state_t      state;
  logic [31:0] tmr;
  logic        rearm;
  logic        halt_pend;
  logic [31:0] dbg_addr_q;
  logic        dbg_wr;

`ifdef PIPE_BOOT_DBG_WRITE_EN
  assign dbg_wr = dbg_we;
`else
  assign dbg_wr = 1'b0;
  wire unused_dbg_wr = &{1'b0, dbg_we, dbg_wdata};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tmr        <= '0;
      rearm      <= 1'b0;
      halt_pend  <= 1'b0;
      cyc_count  <= '0;
      reset_F    <= 1'b1;
      reset_D    <= 1'b1;
      reset_E    <= 1'b1;
      reset_M    <= 1'b1;
      reset_W    <= 1'b1;
      pc_sel     <= 1'b0;
      en_F       <= 1'b0;
      en_D       <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      dbg_rdata  <= '0;
      dbg_valid  <= 1'b0;
      dbg_err    <= 1'b0;
      dbg_addr_q <= '0;
    end else begin
      dbg_valid <= 1'b0;
      dbg_err   <= 1'b0;
      if (dbg_req) begin
        if (state == S_HALT) begin
          dbg_valid  <= 1'b1;
          dbg_addr_q <= dbg_addr;
          if (!dbg_wr) dbg_rdata <= mem_rdata;
        end else begin
          dbg_err <= 1'b1;
        end
      end

      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state     <= S_REL_FD;
            tmr       <= GAP_LD;
            halt_pend <= 1'b0;
            cyc_count <= '0;
            busy      <= 1'b1;
            halted    <= 1'b0;
            // From HALT the E/M/W resets are released, so re-assert everything first.
            if (state == S_HALT) begin
              rearm   <= 1'b1;
              reset_F <= 1'b1;
              reset_D <= 1'b1;
              reset_E <= 1'b1;
              reset_M <= 1'b1;
              reset_W <= 1'b1;
              pc_sel  <= 1'b0;
              en_F    <= 1'b0;
              en_D    <= 1'b0;
            end else begin
              rearm   <= 1'b0;
              reset_F <= 1'b0;
              reset_D <= 1'b0;
            end
          end
        end
        S_REL_FD: begin
          if (halt_req) halt_pend <= 1'b1;
          if (rearm) begin
            rearm   <= 1'b0;
            reset_F <= 1'b0;
            reset_D <= 1'b0;
            tmr     <= GAP_LD;
          end else if (tmr == '0) begin
            state   <= S_REL_E;
            reset_E <= 1'b0;
            tmr     <= GAP_LD;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_REL_E: begin
          if (halt_req) halt_pend <= 1'b1;
          if (tmr == '0) begin
            state   <= S_REL_M;
            reset_M <= 1'b0;
            tmr     <= GAP_LD;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_REL_M: begin
          if (halt_req) halt_pend <= 1'b1;
          if (tmr == '0) begin
            state   <= S_RUN;
            reset_W <= 1'b0;
            pc_sel  <= 1'b1;
            en_F    <= 1'b1;
            en_D    <= 1'b1;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_RUN: begin
          if (cyc_count != '1) cyc_count <= cyc_count + 32'd1;
          if (halt_req || halt_pend || (LIM_EN && cyc_count == RUN_TC)) begin
            state     <= S_DRAIN;
            halt_pend <= 1'b0;
            en_F      <= 1'b0;
            en_D      <= 1'b0;
            reset_D   <= 1'b1;
            tmr       <= DRN_LD;
          end
        end
        S_DRAIN: begin
          if (tmr == '0) begin
            state   <= S_HALT;
            reset_F <= 1'b1;
            busy    <= 1'b0;
            halted  <= 1'b1;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM read is combinational, so the debug address must reach the RAM in the request cycle.
  always_comb begin
    mem_addr  = dbg_addr_q;
    mem_we    = 1'b0;
    mem_wdata = core_wdata;
    case (state)
      S_RUN, S_DRAIN: begin
        mem_addr = core_addr;
        mem_we   = core_we;
      end
      S_HALT: begin
        if (dbg_req) begin
          mem_addr = dbg_addr;
`ifdef PIPE_BOOT_DBG_WRITE_EN
          if (dbg_wr) begin
            mem_we    = 1'b1;
            mem_wdata = dbg_wdata;
          end
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_boot_ctrl.sv
// Randomized bench for pipe_boot_ctrl: two parameterizations against a phase/timeline model.
// Works with or without PIPE_BOOT_DBG_WRITE_EN.
module tb_pipe_boot_ctrl;

`ifdef PIPE_BOOT_DBG_WRITE_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  localparam int GA = 1, LA = 50, DA = 3;
  localparam int GB = 3, LB = 0,  DB = 2;

  localparam int P_IDLE = 0, P_BOOT = 1, P_RUN = 2, P_DRAIN = 3, P_HALT = 4;

  typedef struct {
    int          ph;
    int          t;
    int          off;
    bit          pend;
    logic [31:0] cyc;
    bit          valid;
    bit          err;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, halt_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;

  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_dbg_rdata, a_cyc;
  logic        a_mem_we, a_dbg_valid, a_dbg_err;
  logic        a_rF, a_rD, a_rE, a_rM, a_rW, a_pc, a_enF, a_enD, a_busy, a_halted;

  logic [31:0] b_mem_addr, b_mem_wdata, b_dbg_rdata, b_cyc;
  logic        b_mem_we, b_dbg_valid, b_dbg_err;
  logic        b_rF, b_rD, b_rE, b_rM, b_rW, b_pc, b_enF, b_enD, b_busy, b_halted;

  logic [31:0] ram [256];
  assign a_mem_rdata = ram[a_mem_addr[7:0]];
  always @(posedge clk) if (a_mem_we) ram[a_mem_addr[7:0]] <= a_mem_wdata;

  pipe_boot_ctrl #(.STAGE_GAP(GA), .RUN_LIMIT(LA), .DRAIN_CYC(DA)) u_dut_a (
    .clk(clk), .reset(rst), .start(start), .halt_req(halt_req),
    .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(a_dbg_rdata), .dbg_valid(a_dbg_valid), .dbg_err(a_dbg_err),
    .reset_F(a_rF), .reset_D(a_rD), .reset_E(a_rE), .reset_M(a_rM), .reset_W(a_rW),
    .pc_sel(a_pc), .en_F(a_enF), .en_D(a_enD), .busy(a_busy), .halted(a_halted),
    .cyc_count(a_cyc)
  );

  pipe_boot_ctrl #(.STAGE_GAP(GB), .RUN_LIMIT(LB), .DRAIN_CYC(DB)) u_dut_b (
    .clk(clk), .reset(rst), .start(start), .halt_req(halt_req),
    .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(32'h0),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_valid(b_dbg_valid), .dbg_err(b_dbg_err),
    .reset_F(b_rF), .reset_D(b_rD), .reset_E(b_rE), .reset_M(b_rM), .reset_W(b_rW),
    .pc_sel(b_pc), .en_F(b_enF), .en_D(b_enD), .busy(b_busy), .halted(b_halted),
    .cyc_count(b_cyc)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  mdl_t        ma, mb;
  logic [31:0] mdl_mem [256];
  logic [31:0] exp_rdata, exp_last;
  bit          mux_live = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t step(mdl_t m, int g, int lim, int d, bit rs, bit st, bit hr, bit dq);
    mdl_t n = m;
    if (rs) begin
      n.ph = P_IDLE; n.t = 0; n.off = 0; n.pend = 0; n.cyc = '0; n.valid = 0; n.err = 0;
      return n;
    end
    n.valid = dq && (m.ph == P_HALT);
    n.err   = dq && (m.ph != P_HALT);
    case (m.ph)
      P_IDLE, P_HALT: if (st) begin
        n.ph = P_BOOT; n.t = 0; n.off = (m.ph == P_HALT) ? 1 : 0; n.pend = 0; n.cyc = '0;
      end
      P_BOOT: begin
        n.pend = m.pend | hr;
        n.t    = m.t + 1;
        if (n.t == m.off + 3 * g) begin n.ph = P_RUN; n.t = 0; end
      end
      P_RUN: begin
        if (m.cyc != 32'hFFFF_FFFF) n.cyc = m.cyc + 32'd1;
        if (hr || m.pend || (lim != 0 && n.cyc == 32'(lim))) begin
          n.ph = P_DRAIN; n.t = 0; n.pend = 0;
        end
      end
      P_DRAIN: begin
        n.t = m.t + 1;
        if (n.t == d) n.ph = P_HALT;
      end
      default: ;
    endcase
    return n;
  endfunction

  // {reset_F, reset_D, reset_E, reset_M, reset_W, pc_sel, en_F, en_D, busy, halted}
  function automatic logic [9:0] exp_ctrl(mdl_t m, int g);
    case (m.ph)
      P_BOOT:  return {m.t < m.off, m.t < m.off, m.t < m.off + g, m.t < m.off + 2 * g,
                       1'b1, 3'b000, 1'b1, 1'b0};
      P_RUN:   return 10'b00000_111_10;
      P_DRAIN: return 10'b01000_100_10;
      P_HALT:  return 10'b11000_100_01;
      default: return 10'b11111_000_00;
    endcase
  endfunction

  task automatic cycle();
    logic ew;
    @(negedge clk);
    if (mux_live) begin
      if (ma.ph == P_RUN || ma.ph == P_DRAIN) begin
        check_eq("mux.addr.core", a_mem_addr, core_addr);
        check_eq("mux.we.core", 32'(a_mem_we), 32'(core_we));
        check_eq("mux.wdata.core", a_mem_wdata, core_wdata);
      end else if (ma.ph == P_HALT) begin
        ew = FEAT && dbg_req && dbg_we;
        check_eq("mux.addr.dbg", a_mem_addr, dbg_req ? dbg_addr : exp_last);
        check_eq("mux.we.dbg", 32'(a_mem_we), 32'(ew));
        if (ew) check_eq("mux.wdata.dbg", a_mem_wdata, dbg_wdata);
      end else begin
        check_eq("mux.we.idle", 32'(a_mem_we), 32'd0);
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_rdata = '0;
      exp_last  = '0;
    end else begin
      if ((ma.ph == P_RUN || ma.ph == P_DRAIN) && core_we) mdl_mem[core_addr[7:0]] = core_wdata;
      if (dbg_req && ma.ph == P_HALT) begin
        exp_last = dbg_addr;
        if (FEAT && dbg_we) mdl_mem[dbg_addr[7:0]] = dbg_wdata;
        else exp_rdata = mdl_mem[dbg_addr[7:0]];
      end
    end
    ma = step(ma, GA, LA, DA, rst, start, halt_req, dbg_req);
    mb = step(mb, GB, LB, DB, rst, start, halt_req, dbg_req);
    mux_live = 1'b1;
    #1;
    check_eq("a.ctrl", 32'({a_rF, a_rD, a_rE, a_rM, a_rW, a_pc, a_enF, a_enD, a_busy, a_halted}),
             32'(exp_ctrl(ma, GA)));
    check_eq("a.cyc", a_cyc, ma.cyc);
    check_eq("a.dbg_valid", 32'(a_dbg_valid), 32'(ma.valid));
    check_eq("a.dbg_err", 32'(a_dbg_err), 32'(ma.err));
    check_eq("a.dbg_rdata", a_dbg_rdata, exp_rdata);
    check_eq("b.ctrl", 32'({b_rF, b_rD, b_rE, b_rM, b_rW, b_pc, b_enF, b_enD, b_busy, b_halted}),
             32'(exp_ctrl(mb, GB)));
    check_eq("b.cyc", b_cyc, mb.cyc);
    check_eq("b.dbg_valid", 32'(b_dbg_valid), 32'(mb.valid));
    check_eq("b.dbg_err", 32'(b_dbg_err), 32'(mb.err));
  endtask

  task automatic rand_core();
    core_we    = ($urandom_range(0, 3) == 0);
    core_addr  = 32'($urandom_range(0, 63)) << 2;
    core_wdata = $urandom;
  endtask

  task automatic rand_dbg(input int one_in);
    dbg_req   = ($urandom_range(1, one_in) == 1);
    dbg_we    = $urandom_range(0, 1) == 1;
    dbg_addr  = $urandom & 32'h0000_00FF;
    dbg_wdata = $urandom;
  endtask

  task automatic dbg_idle();
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'(i) * 32'h0101_0101 ^ 32'h0000_00A5;
      mdl_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h0000_00A5;
    end
    ma = '{P_IDLE, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0};
    mb = ma;
    exp_rdata = '0;
    exp_last  = '0;
    rst = 1; start = 0; halt_req = 0;
    core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_idle();
    repeat (2) cycle();
    rst = 0;

    // Boot from IDLE, A stops itself at its run limit.
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 62; i++) begin
      if (i == 5) begin core_we = 1; core_addr = 32'h60; core_wdata = 32'h7; end
      else if (i == 9) begin core_we = 1; core_addr = 32'h84; core_wdata = 32'h19; end
      else begin
        rand_core();
        if (core_addr == 32'h60 || core_addr == 32'h84) core_addr = 32'h40;
      end
      rand_dbg(8);
      cycle();
    end
    dbg_idle(); core_we = 0;

    halt_req = 1; cycle(); halt_req = 0;
    repeat (4) cycle();

    // Back-to-back debug reads, then a debug write followed by a read of the same word.
    dbg_req = 1; dbg_addr = 32'h60; cycle();
    dbg_addr = 32'h84; cycle();
    dbg_req = 0; cycle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h1E; dbg_wdata = 32'hC; cycle();
    dbg_we = 0; cycle();
    dbg_idle(); cycle();
    for (int i = 0; i < 20; i++) begin rand_dbg(2); cycle(); end
    dbg_idle();

    // Restart from HALT with a halt request while A sits in REL_E.
    start = 1; cycle(); start = 0;
    repeat (2) cycle();
    halt_req = 1; cycle(); halt_req = 0;
    for (int i = 0; i < 16; i++) begin rand_core(); cycle(); end

    // Restart, halt, and pull reset in the middle of DRAIN.
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 10; i++) begin rand_core(); cycle(); end
    halt_req = 1; cycle(); halt_req = 0;
    cycle();
    rst = 1; cycle(); rst = 0;
    cycle();

    // Free-running random traffic.
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      start    = ($urandom_range(0, 11) == 0);
      halt_req = ($urandom_range(0, 19) == 0);
      rand_core();
      rand_dbg(5);
      cycle();
    end
    rst = 0; start = 0; halt_req = 0; dbg_idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
